// File: rtl/seg7_window_mux_if.sv
// Bundle of tap bus, operator controls and display outputs for seg7_window_mux.
// The master side drives taps and controls; the slave side drives the display pins.
interface seg7_window_mux_if;
  logic [63:0] TAPS;
  logic        SHIFT_L;
  logic        SHIFT_R;
  logic        BLANK;
  logic [3:0]  SEG_SELECT;
  logic [7:0]  HEX_OUT;
  logic [3:0]  WINDOW_BASE;

  modport master (
    output TAPS, SHIFT_L, SHIFT_R, BLANK,
    input  SEG_SELECT, HEX_OUT, WINDOW_BASE
  );

  modport slave (
    input  TAPS, SHIFT_L, SHIFT_R, BLANK,
    output SEG_SELECT, HEX_OUT, WINDOW_BASE
  );
endinterface

// File: rtl/seg7_window_mux.sv
// Shows a movable 4-tap window of a 16x4-bit tap bus on a 4-digit active-low
// seven-segment display, scanning one digit per REFRESH_DIV clocks.
module seg7_window_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_WIDTH   = 17
) (
  input logic              CLK,
  input logic              RESET,
  seg7_window_mux_if.slave bus
);

  localparam logic [DIV_WIDTH-1:0] CntMax = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           digit_q, digit_d;
  logic [3:0]           base_q, base_d;
  logic                 shl_prev_q, shr_prev_q;
  logic [3:0]           seg_q, seg_d;
  logic [7:0]           hex_q, hex_d;

  logic       cnt_wrap;
  logic       rise_l, rise_r;
  logic [3:0] tap_idx;
  logic [3:0] tap_val;
  logic [6:0] glyph;

  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    digit_d  = cnt_wrap ? digit_q + 2'd1 : digit_q;

    // Simultaneous rising edges cancel out.
    rise_l = bus.SHIFT_L & ~shl_prev_q;
    rise_r = bus.SHIFT_R & ~shr_prev_q;
    base_d = base_q;
    if (rise_l && !rise_r) begin
      base_d = base_q + 4'd1;
    end else if (rise_r && !rise_l) begin
      base_d = base_q - 4'd1;
    end
  end

  always_comb begin
    tap_idx = base_q + {2'b00, digit_q};
    tap_val = bus.TAPS[{tap_idx, 2'b00} +: 4];
    glyph   = 7'b1111111;
    unique case (tap_val)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase

    // Anode and cathode registers load together so no frame mixes two digits.
    seg_d = bus.BLANK ? 4'b1111 : ~(4'b0001 << digit_q);
    hex_d = {~((digit_q == 2'd0) && (base_q == 4'd0)), glyph};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= '0;
      digit_q    <= 2'd0;
      base_q     <= 4'd0;
      // Held buttons are treated as already pressed, so no step after reset.
      shl_prev_q <= bus.SHIFT_L;
      shr_prev_q <= bus.SHIFT_R;
      seg_q      <= 4'b1111;
      hex_q      <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      base_q     <= base_d;
      shl_prev_q <= bus.SHIFT_L;
      shr_prev_q <= bus.SHIFT_R;
      seg_q      <= seg_d;
      hex_q      <= hex_d;
    end
  end

  assign bus.SEG_SELECT  = seg_q;
  assign bus.HEX_OUT     = hex_q;
  assign bus.WINDOW_BASE = base_q;

endmodule

// File: tb/tb_seg7_window_mux.sv
// Scoreboard bench for seg7_window_mux: directed scenarios then random traffic,
// checked against a cycle-count based model of the display scan.
module tb_seg7_window_mux;

  localparam int RD = 4;

  localparam logic [6:0] SegTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] seg;
    logic [7:0] hex;
    logic [3:0] base;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg7_window_mux_if bus ();

  seg7_window_mux #(
    .REFRESH_DIV(RD),
    .DIV_WIDTH  (2)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Requested input levels for the next tick.
  logic        r_rst   = 1'b1;
  logic        r_l     = 1'b0;
  logic        r_r     = 1'b0;
  logic        r_blank = 1'b0;
  logic [63:0] r_taps  = 64'hFEDCBA9876543210;

  // Reference model state: edges since reset, window base, last button levels.
  int m_cyc  = 0;
  int m_base = 0;
  bit m_prev_l = 1'b0;
  bit m_prev_r = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   dig;
    int   idx;
    logic [3:0] tap;
    bit   rl, rr;
    @(negedge clk);
    rst         = r_rst;
    bus.TAPS    = r_taps;
    bus.SHIFT_L = r_l;
    bus.SHIFT_R = r_r;
    bus.BLANK   = r_blank;
    if (r_rst) begin
      e.seg  = 4'hF;
      e.hex  = 8'hFF;
      e.base = 4'h0;
      m_base = 0;
      m_cyc  = 0;
    end else begin
      dig   = (m_cyc / RD) % 4;
      idx   = (m_base + dig) % 16;
      tap   = 4'(r_taps >> (4 * idx));
      e.seg = r_blank ? 4'hF : ~(4'(1) << dig);
      e.hex = {(dig == 0 && m_base == 0) ? 1'b0 : 1'b1, SegTab[tap]};
      rl = r_l && !m_prev_l;
      rr = r_r && !m_prev_r;
      if (rl && !rr) m_base = (m_base + 1) % 16;
      if (rr && !rl) m_base = (m_base + 15) % 16;
      e.base = 4'(m_base);
      m_cyc++;
    end
    m_prev_l = r_l;
    m_prev_r = r_r;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_l();
    r_l = 1'b1; run(2);
    r_l = 1'b0; run(2);
  endtask

  // Monitor: compare every registered output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("seg_select", {4'h0, bus.SEG_SELECT}, {4'h0, e.seg});
        check("hex_out", bus.HEX_OUT, e.hex);
        check("window_base", {4'h0, bus.WINDOW_BASE}, {4'h0, e.base});
      end
    end
  end

  initial begin
    bus.TAPS    = r_taps;
    bus.SHIFT_L = 1'b0;
    bus.SHIFT_R = 1'b0;
    bus.BLANK   = 1'b0;

    // Reset and one full scan of taps 0..3.
    r_rst = 1'b1; run(2);
    r_rst = 1'b0; run(20);

    // Three left steps.
    pulse_l(); pulse_l(); pulse_l();
    run(16);

    // From base 0 one right step wraps to 15.
    r_rst = 1'b1; run(1);
    r_rst = 1'b0; run(3);
    r_r = 1'b1; run(2);
    r_r = 1'b0; run(16);

    // Held level steps once; simultaneous rising edges cancel.
    r_l = 1'b1; run(20);
    r_l = 1'b0; run(3);
    r_l = 1'b1; r_r = 1'b1; run(2);
    r_l = 1'b0; r_r = 1'b0; run(6);

    // Blank mid-scan; the scan keeps running underneath.
    run(2);
    r_blank = 1'b1; run(10);
    r_blank = 1'b0; run(10);

    // Button held through a mid-scan reset.
    r_l = 1'b1;
    r_rst = 1'b1; run(2);
    r_rst = 1'b0; run(8);
    r_l = 1'b0; run(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) r_taps = {$urandom, $urandom};
      if ($urandom_range(3) == 0) r_l = ~r_l;
      if ($urandom_range(3) == 0) r_r = ~r_r;
      if ($urandom_range(5) == 0) r_blank = ~r_blank;
      r_rst = ($urandom_range(59) == 0);
      tick();
    end
    r_rst = 1'b0;

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
